// File: rtl/pe_conf_ctx_loader.sv
// Multi-context PE configuration loader: streams INWD-bit beats into NCTX shadow
// contexts and swaps the active context at tile boundaries via req/ack.
module pe_conf_ctx_loader #(
  parameter  int CONFWD = 88,
  parameter  int INWD   = 16,
  parameter  int NCTX   = 2,
  localparam int NBEAT  = (CONFWD + INWD - 1) / INWD,
  localparam int CTXWD  = $clog2(NCTX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_conf_dval,
  output logic              i_conf_rdy,
  input  logic [INWD-1:0]   i_conf_data,
  input  logic [CTXWD-1:0]  i_conf_ctx,
  input  logic              i_act_req,
  input  logic [CTXWD-1:0]  i_act_ctx,
  output logic              o_act_ack,
  input  logic              i_pe_busy,
  output logic [CONFWD-1:0] o_conf,
  output logic              o_conf_vld,
  output logic [NCTX-1:0]   o_ctx_vld,
  output logic [CTXWD-1:0]  o_act_idx
);

  localparam int CNTWD = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int PADWD = NBEAT * INWD;

  typedef enum logic {IDLE, LOAD} state_e;

  state_e             state_q;
  logic [CNTWD-1:0]   cnt_q;
  logic [CTXWD-1:0]   ld_ctx_q;
  logic [CTXWD-1:0]   act_idx_q;
  logic [CONFWD-1:0]  ctx_q [NCTX];
  logic [CONFWD-1:0]  conf_q;
  logic               conf_vld_q;
  logic [NCTX-1:0]    ctx_vld_q;

  logic [CTXWD-1:0]   tgt;
  logic               beat_acc;
  logic               last_beat;
  logic               ack;
  logic [PADWD-1:0]   pad;
  logic [CONFWD-1:0]  wr_word;

  // The context in use by the PE must never be overwritten.
  assign tgt        = (state_q == IDLE) ? i_conf_ctx : ld_ctx_q;
  assign i_conf_rdy = ~(conf_vld_q && (tgt == act_idx_q));
  assign beat_acc   = i_conf_dval & i_conf_rdy;
  assign last_beat  = (cnt_q == CNTWD'(NBEAT - 1));
  assign ack        = ~rst & i_act_req & ctx_vld_q[i_act_ctx] & ~i_pe_busy &
                      ~((state_q == LOAD) && (ld_ctx_q == i_act_ctx));

  // Padded merge so the last beat's unused upper bits simply fall off.
  always_comb begin
    pad                              = '0;
    pad[CONFWD-1:0]                  = ctx_q[tgt];
    pad[int'(cnt_q)*INWD +: INWD]    = i_conf_data;
    wr_word                          = pad[CONFWD-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ld_ctx_q   <= '0;
      act_idx_q  <= '0;
      conf_q     <= '0;
      conf_vld_q <= 1'b0;
      ctx_vld_q  <= '0;
      for (int i = 0; i < NCTX; i++) ctx_q[i] <= '0;
    end else begin
      if (ack) begin
        act_idx_q  <= i_act_ctx;
        conf_q     <= ctx_q[i_act_ctx];
        conf_vld_q <= 1'b1;
      end
      if (beat_acc) begin
        ctx_q[tgt] <= wr_word;
        if (state_q == IDLE) ld_ctx_q <= i_conf_ctx;
        if (last_beat) begin
          ctx_vld_q[tgt] <= 1'b1;
          cnt_q          <= '0;
          state_q        <= IDLE;
        end else begin
          if (state_q == IDLE) ctx_vld_q[tgt] <= 1'b0;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= LOAD;
        end
      end
    end
  end

  assign o_act_ack  = ack;
  assign o_conf     = conf_q;
  assign o_conf_vld = conf_vld_q;
  assign o_ctx_vld  = ctx_vld_q;
  assign o_act_idx  = act_idx_q;

endmodule

// File: tb/tb_pe_conf_ctx_loader.sv
// Bench for pe_conf_ctx_loader: frame-level reference model with an activation
// scoreboard, directed tile-boundary scenarios and a random phase.
module tb_pe_conf_ctx_loader;
  localparam int CONFWD = 88;
  localparam int INWD   = 16;
  localparam int NCTX   = 2;
  localparam int NBEAT  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_conf_dval;
  logic              i_conf_rdy;
  logic [INWD-1:0]   i_conf_data;
  logic              i_conf_ctx;
  logic              i_act_req;
  logic              i_act_ctx;
  logic              o_act_ack;
  logic              i_pe_busy;
  logic [CONFWD-1:0] o_conf;
  logic              o_conf_vld;
  logic [NCTX-1:0]   o_ctx_vld;
  logic              o_act_idx;

  pe_conf_ctx_loader #(.CONFWD(CONFWD), .INWD(INWD), .NCTX(NCTX)) dut (
    .clk(clk), .rst(rst),
    .i_conf_dval(i_conf_dval), .i_conf_rdy(i_conf_rdy),
    .i_conf_data(i_conf_data), .i_conf_ctx(i_conf_ctx),
    .i_act_req(i_act_req), .i_act_ctx(i_act_ctx), .o_act_ack(o_act_ack),
    .i_pe_busy(i_pe_busy),
    .o_conf(o_conf), .o_conf_vld(o_conf_vld), .o_ctx_vld(o_ctx_vld), .o_act_idx(o_act_idx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [CONFWD-1:0] obs, input logic [CONFWD-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: frames are assembled from whole beat lists, not written in place.
  bit                mon_en = 1'b0;
  logic [CONFWD-1:0] m_frame [NCTX];
  logic [NCTX-1:0]   m_vld;
  bit                m_state, m_ld, m_act, m_cvld;
  logic [CONFWD-1:0] m_conf;
  logic [INWD-1:0]   m_beats[$];
  logic [CONFWD-1:0] exq[$];

  task automatic model_reset();
    for (int i = 0; i < NCTX; i++) m_frame[i] = '0;
    m_vld = '0; m_state = 0; m_ld = 0; m_act = 0; m_cvld = 0; m_conf = '0;
    m_beats.delete(); exq.delete();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic              erdy, eack;
      logic [CONFWD-1:0] f;
      bit                tgt;
      if (exq.size() > 0) m_conf = exq.pop_front();
      tgt  = m_state ? m_ld : i_conf_ctx;
      erdy = !(m_cvld && tgt == m_act);
      eack = i_act_req && m_vld[i_act_ctx] && !i_pe_busy && !(m_state && m_ld == i_act_ctx) && !rst;
      chk("rdy",      i_conf_rdy, erdy);
      chk("ack",      o_act_ack,  eack);
      chk("conf",     o_conf,     m_conf);
      chk("conf_vld", o_conf_vld, m_cvld);
      chk("act_idx",  o_act_idx,  m_act);
      chk("ctx_vld",  o_ctx_vld,  m_vld);
      if (rst) model_reset();
      else begin
        if (eack) begin
          exq.push_back(m_frame[i_act_ctx]);
          m_act = i_act_ctx; m_cvld = 1;
        end
        if (i_conf_dval && erdy) begin
          if (!m_state) begin
            m_ld = i_conf_ctx; m_vld[m_ld] = 1'b0; m_beats.delete();
          end
          m_beats.push_back(i_conf_data);
          if (m_beats.size() == NBEAT) begin
            f = '0;
            for (int i = 0; i < NBEAT; i++) f |= CONFWD'(m_beats[i]) << (i * INWD);
            m_frame[m_ld] = f; m_vld[m_ld] = 1'b1; m_state = 0;
          end else m_state = 1;
        end
      end
    end
  end

  // Drivers run from posedge+1; acceptance is sampled on the negedge.
  task automatic send(input logic [INWD-1:0] d, input bit c);
    bit a = 0;
    i_conf_dval = 1; i_conf_data = d; i_conf_ctx = c;
    for (int k = 0; k < 200 && !a; k++) begin
      @(negedge clk); a = i_conf_rdy;
      @(posedge clk); #1;
    end
    i_conf_dval = 0;
    if (!a) chk("beat_timeout", a, 1);
  endtask

  task automatic frame(input bit c, input logic [INWD-1:0] base);
    for (int i = 0; i < NBEAT; i++) send(base + INWD'(i + 1), c);
  endtask

  task automatic act(input bit c);
    bit a = 0;
    i_act_req = 1; i_act_ctx = c;
    for (int k = 0; k < 200 && !a; k++) begin
      @(negedge clk); a = o_act_ack;
      @(posedge clk); #1;
    end
    i_act_req = 0;
    if (!a) chk("act_timeout", a, 1);
  endtask

  initial begin
    bit acc_last, ack_last;
    rst = 1; i_conf_dval = 0; i_conf_data = '0; i_conf_ctx = 0;
    i_act_req = 0; i_act_ctx = 0; i_pe_busy = 0;
    model_reset();
    @(posedge clk); #1;
    mon_en = 1;
    @(posedge clk); #1;
    chk("rst_conf", o_conf, '0);
    chk("rst_ctx_vld", o_ctx_vld, '0);
    rst = 0;

    // 1: first frame to ctx0, activate
    frame(0, 16'h0000);
    @(negedge clk); chk("t1_ctx_vld", o_ctx_vld, 2'b01);
    @(posedge clk); #1;
    act(0);
    @(negedge clk);
    chk("t1_conf", o_conf, 88'h06_0005_0004_0003_0002_0001);
    chk("t1_conf_vld", o_conf_vld, 1'b1);
    @(posedge clk); #1;

    // 2: background load of ctx1 under busy, request held throughout
    i_pe_busy = 1;
    fork
      begin frame(1, 16'h0010); repeat (3) @(posedge clk); #1; i_pe_busy = 0; end
      act(1);
    join
    @(negedge clk);
    chk("t2_idx", o_act_idx, 1'b1);
    chk("t2_conf", o_conf, 88'h16_0015_0014_0013_0012_0011);
    @(posedge clk); #1;

    // 3: load into the live context is held off until the other one is activated
    act(0);
    fork
      frame(0, 16'h0020);
      begin
        @(negedge clk); chk("t3_rdy_blocked", i_conf_rdy, 1'b0);
        repeat (3) @(posedge clk); #1;
        act(1);
      end
    join
    act(0);
    @(negedge clk); chk("t3_conf", o_conf, 88'h26_0025_0024_0023_0022_0021);
    @(posedge clk); #1;

    // 4: final beat and activation request for the same context collide
    for (int i = 0; i < NBEAT - 1; i++) send(16'h0031 + 16'(i), 1);
    i_conf_dval = 1; i_conf_data = 16'h0036; i_conf_ctx = 1;
    i_act_req = 1; i_act_ctx = 1;
    @(negedge clk); chk("t4_rdy", i_conf_rdy, 1'b1); chk("t4_ack_collide", o_act_ack, 1'b0);
    @(posedge clk); #1; i_conf_dval = 0;
    @(negedge clk); chk("t4_ack_next", o_act_ack, 1'b1);
    @(posedge clk); #1; i_act_req = 0;
    @(negedge clk); chk("t4_idx", o_act_idx, 1'b1);
    chk("t4_conf", o_conf, 88'h36_0035_0034_0033_0032_0031);
    @(posedge clk); #1;

    // 5: reset in the middle of a frame
    for (int i = 0; i < 3; i++) send(16'h00A1 + 16'(i), 0);
    rst = 1;
    @(posedge clk); #1; rst = 0;
    @(negedge clk);
    chk("t5_ctx_vld", o_ctx_vld, '0);
    chk("t5_conf_vld", o_conf_vld, 1'b0);
    @(posedge clk); #1;
    frame(0, 16'h0040);
    act(0);
    @(negedge clk); chk("t5_conf", o_conf, 88'h46_0045_0044_0043_0042_0041);
    @(posedge clk); #1;
    frame(1, 16'h0050);

    // 6: random beat gaps, activation timing and busy
    acc_last = 0; ack_last = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (!i_conf_dval || acc_last) begin
        i_conf_dval = ($urandom_range(0, 2) != 0);
        i_conf_data = 16'($urandom);
        i_conf_ctx  = 1'($urandom_range(0, 1));
      end
      if (!i_act_req || ack_last) begin
        i_act_req = ($urandom_range(0, 3) == 0);
        i_act_ctx = 1'($urandom_range(0, 1));
      end
      i_pe_busy = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      acc_last = i_conf_dval & i_conf_rdy;
      ack_last = o_act_ack;
      @(posedge clk); #1;
    end
    i_conf_dval = 0; i_act_req = 0; i_pe_busy = 0;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
